// File: rtl/stage_3_ex_pkg.sv
// Shared definitions for the execute stage.
//   - Bus widths for the ID->EX and EX->MEM pipeline buses.
//   - Bit positions of the one-hot alu_op vector.
//   - Encoding of the data-memory request FSM.
//   - Packed views of both pipeline buses.
package stage_3_ex_pkg;

    localparam int unsigned BUS_2_3_W = 117;
    localparam int unsigned BUS_3_4_W = 71;
    localparam int unsigned ALU_OP_W  = 12;

    // One-hot alu_op bit positions
    localparam int unsigned ALU_ADD  = 0;
    localparam int unsigned ALU_SUB  = 1;
    localparam int unsigned ALU_SLT  = 2;
    localparam int unsigned ALU_SLTU = 3;
    localparam int unsigned ALU_AND  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_OR   = 6;
    localparam int unsigned ALU_XOR  = 7;
    localparam int unsigned ALU_SLL  = 8;
    localparam int unsigned ALU_SRL  = 9;
    localparam int unsigned ALU_SRA  = 10;
    localparam int unsigned ALU_LUI  = 11;

    // MemIssued: address accepted, instruction still waiting for MEM to take it.
    typedef enum logic [1:0] {
        MemIdle     = 2'd0,
        MemWaitAddr = 2'd1,
        MemIssued   = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic                rf_we;
        logic [4:0]          dest;
        logic                res_from_mem;
        logic [31:0]         alu_src1;
        logic [31:0]         alu_src2;
        logic [ALU_OP_W-1:0] alu_op;
        logic                mem_we;
        logic                mem_en;
        logic [31:0]         pc;
    } id_ex_bus_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  dest;
        logic        res_from_mem;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } ex_mem_bus_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage.
//   alu_op : one-hot operation select (all-zero yields 0)
//   src1   : first operand
//   src2   : second operand; [4:0] is the shift amount for shifts
//   result : 32-bit wrap-around result, no overflow trap
module ex_alu
    import stage_3_ex_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         src1,
    input  logic [31:0]         src2,
    output logic [31:0]         result
);

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] sll_res;
    logic [31:0] srl_res;
    logic [31:0] sra_res;

    assign add_res  = src1 + src2;
    assign sub_res  = src1 - src2;
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};
    assign sll_res  = src1 << src2[4:0];
    assign srl_res  = src1 >> src2[4:0];
    assign sra_res  = $unsigned($signed(src1) >>> src2[4:0]);

    // AND-OR mux: a zero alu_op naturally produces 0.
    assign result = ({32{alu_op[ALU_ADD]}}  & add_res)
                  | ({32{alu_op[ALU_SUB]}}  & sub_res)
                  | ({32{alu_op[ALU_SLT]}}  & slt_res)
                  | ({32{alu_op[ALU_SLTU]}} & sltu_res)
                  | ({32{alu_op[ALU_AND]}}  & (src1 & src2))
                  | ({32{alu_op[ALU_NOR]}}  & ~(src1 | src2))
                  | ({32{alu_op[ALU_OR]}}   & (src1 | src2))
                  | ({32{alu_op[ALU_XOR]}}  & (src1 ^ src2))
                  | ({32{alu_op[ALU_SLL]}}  & sll_res)
                  | ({32{alu_op[ALU_SRL]}}  & srl_res)
                  | ({32{alu_op[ALU_SRA]}}  & sra_res)
                  | ({32{alu_op[ALU_LUI]}}  & src2);

endmodule

// File: rtl/stage_3_ex.sv
// Execute stage of the 5-stage in-order pipeline.
// Registers the ID bus and store data, computes the ALU result and issues
// data-memory requests on an SRAM-like req/addr_ok bus.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   valid_2 / allow_3   : ID->EX handshake
//   valid_3 / allow_4   : EX->MEM handshake
//   stage_2_to_3        : {rf_we, dest, res_from_mem, src1, src2, alu_op, mem_we, mem_en, pc}
//   memory_write_data   : store data from ID
//   stage_3_to_4        : {rf_we, dest, res_from_mem, alu_result, pc}
//   rf_waddr_3_fwd      : destination register for ID hazard detection (0 if none)
//   data_sram_*         : data-memory request bus
// Optional build macro EX_DATA_FWD_EN adds rf_wdata_3_fwd / rf_fwd_ok_3 so ID can
// bypass non-load EX results instead of stalling.
module stage_3_ex
    import stage_3_ex_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 valid_2,
    output logic                 allow_3,
    output logic                 valid_3,
    input  logic                 allow_4,
    input  logic [BUS_2_3_W-1:0] stage_2_to_3,
    input  logic [31:0]          memory_write_data,
    output logic [BUS_3_4_W-1:0] stage_3_to_4,
    output logic [4:0]           rf_waddr_3_fwd,
`ifdef EX_DATA_FWD_EN
    output logic [31:0]          rf_wdata_3_fwd,
    output logic                 rf_fwd_ok_3,
`endif
    output logic                 data_sram_req,
    output logic                 data_sram_wr,
    output logic [3:0]           data_sram_wstrb,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata,
    input  logic                 data_sram_addr_ok
);

    id_ex_bus_t  bus_in;
    id_ex_bus_t  bus_q;
    logic [31:0] wdata_q;
    logic        valid_q;
    mem_state_e  state_q;
    mem_state_e  state_d;
    logic        readygo_3;
    logic [31:0] alu_result;
    ex_mem_bus_t out_bus;

    assign bus_in = id_ex_bus_t'(stage_2_to_3);

    ex_alu u_alu (
        .alu_op (bus_q.alu_op),
        .src1   (bus_q.alu_src1),
        .src2   (bus_q.alu_src2),
        .result (alu_result)
    );

    // A memory op may leave once its address has been accepted, either
    // earlier (MemIssued) or in this very cycle.
    assign readygo_3 = ~bus_q.mem_en
                     | (state_q == MemIssued)
                     | ((state_q == MemWaitAddr) & data_sram_addr_ok);
    assign allow_3   = ~valid_q | (readygo_3 & allow_4);

    always_comb begin
        state_d = state_q;
        if (allow_3) begin
            // The outgoing instruction is done; state follows the new capture.
            state_d = (valid_2 & bus_in.mem_en) ? MemWaitAddr : MemIdle;
        end else if ((state_q == MemWaitAddr) & data_sram_addr_ok) begin
            // Address accepted but MEM is full: remember it to block a re-issue.
            state_d = MemIssued;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            state_q <= MemIdle;
            bus_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (allow_3) begin
                valid_q <= valid_2;
                if (valid_2) begin
                    bus_q   <= bus_in;
                    wdata_q <= memory_write_data;
                end
            end
        end
    end

    always_comb begin
        out_bus = '0;
        if (valid_q) begin
            out_bus.rf_we        = bus_q.rf_we;
            out_bus.dest         = bus_q.dest;
            out_bus.res_from_mem = bus_q.res_from_mem;
            out_bus.alu_result   = alu_result;
            out_bus.pc           = bus_q.pc;
        end
    end

    assign valid_3        = valid_q;
    assign stage_3_to_4   = out_bus;
    assign rf_waddr_3_fwd = (valid_q & bus_q.rf_we) ? bus_q.dest : 5'd0;

`ifdef EX_DATA_FWD_EN
    assign rf_wdata_3_fwd = valid_q ? alu_result : 32'd0;
    assign rf_fwd_ok_3    = valid_q & bus_q.rf_we & ~bus_q.res_from_mem;
`endif

    assign data_sram_req   = valid_q & bus_q.mem_en & (state_q == MemWaitAddr);
    assign data_sram_wr    = valid_q & bus_q.mem_we;
    assign data_sram_wstrb = (valid_q & bus_q.mem_we) ? 4'hF : 4'h0;
    assign data_sram_addr  = valid_q ? alu_result : 32'd0;
    assign data_sram_wdata = valid_q ? wdata_q : 32'd0;

endmodule

// File: tb/tb_stage_3_ex.sv
module tb_stage_3_ex;

    logic         clk;
    logic         reset;
    logic         valid_2;
    logic         allow_3;
    logic         valid_3;
    logic         allow_4;
    logic [116:0] stage_2_to_3;
    logic [31:0]  memory_write_data;
    logic [70:0]  stage_3_to_4;
    logic [4:0]   rf_waddr_3_fwd;
`ifdef EX_DATA_FWD_EN
    logic [31:0]  rf_wdata_3_fwd;
    logic         rf_fwd_ok_3;
`endif
    logic         data_sram_req;
    logic         data_sram_wr;
    logic [3:0]   data_sram_wstrb;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         data_sram_addr_ok;

    int checks = 0;
    int errors = 0;

    stage_3_ex dut (
        .clk               (clk),
        .reset             (reset),
        .valid_2           (valid_2),
        .allow_3           (allow_3),
        .valid_3           (valid_3),
        .allow_4           (allow_4),
        .stage_2_to_3      (stage_2_to_3),
        .memory_write_data (memory_write_data),
        .stage_3_to_4      (stage_3_to_4),
        .rf_waddr_3_fwd    (rf_waddr_3_fwd),
`ifdef EX_DATA_FWD_EN
        .rf_wdata_3_fwd    (rf_wdata_3_fwd),
        .rf_fwd_ok_3       (rf_fwd_ok_3),
`endif
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_NOR  = 12'h020;
    localparam logic [11:0] OP_OR   = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    function automatic logic [116:0] mk_bus(input logic rf_we, input logic [4:0] dest,
                                            input logic rfm, input logic [31:0] s1,
                                            input logic [31:0] s2, input logic [11:0] op,
                                            input logic mem_we, input logic mem_en,
                                            input logic [31:0] pc);
        return {rf_we, dest, rfm, s1, s2, op, mem_we, mem_en, pc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid_2 = 1'b0;
        allow_4 = 1'b1;
        data_sram_addr_ok = 1'b0;
        stage_2_to_3 = '0;
        memory_write_data = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (valid_3 !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", valid_3);
        end
        checks++;
        if (data_sram_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: got %b want 0", data_sram_req);
        end
        checks++;
        if (stage_3_to_4 !== 71'd0) begin
            errors++; $display("FAIL reset_bus: got %h want 0", stage_3_to_4);
        end
        checks++;
        if (allow_3 !== 1'b1) begin
            errors++; $display("FAIL reset_allow: got %b want 1", allow_3);
        end
        checks++;
        if (rf_waddr_3_fwd !== 5'd0) begin
            errors++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr_3_fwd);
        end
    endtask

    task automatic test_add();
        logic [70:0] exp_bus;
        exp_bus = {1'b1, 5'd3, 1'b0, 32'd12, 32'h0000_0100};
        valid_2 = 1'b1;
        allow_4 = 1'b1;
        stage_2_to_3 = mk_bus(1'b1, 5'd3, 1'b0, 32'd5, 32'd7, OP_ADD, 1'b0, 1'b0, 32'h100);
        step();
        valid_2 = 1'b0;
        #1;
        checks++;
        if (valid_3 !== 1'b1) begin
            errors++; $display("FAIL add_valid: got %b want 1", valid_3);
        end
        checks++;
        if (stage_3_to_4 !== exp_bus) begin
            errors++; $display("FAIL add_bus: got %h want %h", stage_3_to_4, exp_bus);
        end
        checks++;
        if (rf_waddr_3_fwd !== 5'd3) begin
            errors++; $display("FAIL add_waddr: got %0d want 3", rf_waddr_3_fwd);
        end
        checks++;
        if (allow_3 !== 1'b1) begin
            errors++; $display("FAIL add_allow: got %b want 1", allow_3);
        end
        checks++;
        if (data_sram_req !== 1'b0) begin
            errors++; $display("FAIL add_req: got %b want 0", data_sram_req);
        end
        step();
        checks++;
        if (valid_3 !== 1'b0) begin
            errors++; $display("FAIL add_drain: got %b want 0", valid_3);
        end
    endtask

    task automatic test_alu();
        logic [11:0] ops [12];
        logic [31:0] s1s [12];
        logic [31:0] s2s [12];
        logic [31:0] exps[12];
        ops[0]  = OP_SRA;  s1s[0]  = 32'h8000_0000; s2s[0]  = 32'd4;        exps[0]  = 32'hF800_0000;
        ops[1]  = OP_SLTU; s1s[1]  = 32'd1;         s2s[1]  = 32'hFFFF_FFFF; exps[1]  = 32'd1;
        ops[2]  = OP_SLT;  s1s[2]  = 32'd1;         s2s[2]  = 32'hFFFF_FFFF; exps[2]  = 32'd0;
        ops[3]  = OP_SUB;  s1s[3]  = 32'd5;         s2s[3]  = 32'd7;        exps[3]  = 32'hFFFF_FFFE;
        ops[4]  = OP_NOR;  s1s[4]  = 32'hF0F0_F0F0; s2s[4]  = 32'h0F0F_0F00; exps[4]  = 32'h0000_000F;
        ops[5]  = OP_SLL;  s1s[5]  = 32'd1;         s2s[5]  = 32'h23;       exps[5]  = 32'd8;
        ops[6]  = OP_SRL;  s1s[6]  = 32'h8000_0000; s2s[6]  = 32'd4;        exps[6]  = 32'h0800_0000;
        ops[7]  = OP_LUI;  s1s[7]  = 32'hAAAA_AAAA; s2s[7]  = 32'h1234_0000; exps[7]  = 32'h1234_0000;
        ops[8]  = OP_XOR;  s1s[8]  = 32'hFF00_FF00; s2s[8]  = 32'h0FF0_0FF0; exps[8]  = 32'hF0F0_F0F0;
        ops[9]  = OP_AND;  s1s[9]  = 32'hFF00_FF00; s2s[9]  = 32'h0FF0_0FF0; exps[9]  = 32'h0F00_0F00;
        ops[10] = OP_OR;   s1s[10] = 32'hFF00_FF00; s2s[10] = 32'h0FF0_0FF0; exps[10] = 32'hFFF0_FFF0;
        ops[11] = 12'h000; s1s[11] = 32'h1234_5678; s2s[11] = 32'h1111_1111; exps[11] = 32'd0;
        allow_4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            valid_2 = 1'b1;
            stage_2_to_3 = mk_bus(1'b1, 5'd9, 1'b0, s1s[i], s2s[i], ops[i], 1'b0, 1'b0, 32'h200);
            step();
            checks++;
            if (stage_3_to_4[63:32] !== exps[i]) begin
                errors++;
                $display("FAIL alu_%0d: got %h want %h", i, stage_3_to_4[63:32], exps[i]);
            end
        end
        // Wrap-around add
        stage_2_to_3 = mk_bus(1'b1, 5'd9, 1'b0, 32'hFFFF_FFFF, 32'd2, OP_ADD, 1'b0, 1'b0, 32'h0);
        step();
        valid_2 = 1'b0;
        checks++;
        if (stage_3_to_4[63:32] !== 32'd1) begin
            errors++; $display("FAIL alu_wrap: got %h want 1", stage_3_to_4[63:32]);
        end
        step();
    endtask

    task automatic test_store();
        valid_2 = 1'b1;
        allow_4 = 1'b1;
        data_sram_addr_ok = 1'b0;
        stage_2_to_3 = mk_bus(1'b0, 5'd0, 1'b0, 32'h1000, 32'h8, OP_ADD, 1'b1, 1'b1, 32'h300);
        memory_write_data = 32'hDEAD_BEEF;
        step();
        valid_2 = 1'b0;
        memory_write_data = 32'h0;
        #1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({data_sram_req, data_sram_wr, data_sram_wstrb} !== 6'b11_1111) begin
                errors++;
                $display("FAIL store_req_%0d: got req=%b wr=%b wstrb=%h want 1 1 f", c,
                         data_sram_req, data_sram_wr, data_sram_wstrb);
            end
            checks++;
            if (data_sram_addr !== 32'h1008 || data_sram_wdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL store_addr_%0d: got %h/%h want 00001008/deadbeef", c,
                         data_sram_addr, data_sram_wdata);
            end
            checks++;
            if (allow_3 !== 1'b0 || valid_3 !== 1'b1) begin
                errors++;
                $display("FAIL store_hold_%0d: got allow=%b valid=%b want 0 1", c, allow_3,
                         valid_3);
            end
            step();
        end
        data_sram_addr_ok = 1'b1;
        #1;
        checks++;
        if (allow_3 !== 1'b1 || data_sram_req !== 1'b1) begin
            errors++;
            $display("FAIL store_ok: got allow=%b req=%b want 1 1", allow_3, data_sram_req);
        end
        step();
        data_sram_addr_ok = 1'b0;
        #1;
        checks++;
        if (valid_3 !== 1'b0 || data_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL store_leave: got valid=%b req=%b want 0 0", valid_3, data_sram_req);
        end
    endtask

    task automatic test_load_stall();
        int handshakes = 0;
        valid_2 = 1'b1;
        allow_4 = 1'b0;
        data_sram_addr_ok = 1'b1;
        stage_2_to_3 = mk_bus(1'b1, 5'd5, 1'b1, 32'h2000, 32'h4, OP_ADD, 1'b0, 1'b1, 32'h400);
        step();
        valid_2 = 1'b0;
        #1;
        checks++;
        if ({data_sram_req, data_sram_wr, data_sram_wstrb} !== 6'b10_0000) begin
            errors++;
            $display("FAIL load_req: got req=%b wr=%b wstrb=%h want 1 0 0", data_sram_req,
                     data_sram_wr, data_sram_wstrb);
        end
        checks++;
        if (allow_3 !== 1'b0) begin
            errors++; $display("FAIL load_allow0: got %b want 0", allow_3);
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 3) allow_4 = 1'b1;
            #1;
            if (data_sram_req && data_sram_addr_ok) handshakes++;
            if (c == 1 || c == 2) begin
                checks++;
                if (data_sram_req !== 1'b0 || valid_3 !== 1'b1 || allow_3 !== 1'b0) begin
                    errors++;
                    $display("FAIL load_issued_%0d: got req=%b valid=%b allow=%b want 0 1 0",
                             c, data_sram_req, valid_3, allow_3);
                end
            end
            if (c == 3) begin
                checks++;
                if (allow_3 !== 1'b1) begin
                    errors++; $display("FAIL load_release: got %b want 1", allow_3);
                end
            end
            step();
        end
        data_sram_addr_ok = 1'b0;
        checks++;
        if (handshakes != 1) begin
            errors++; $display("FAIL load_one_req: got %0d requests want 1", handshakes);
        end
        checks++;
        if (valid_3 !== 1'b0) begin
            errors++; $display("FAIL load_leave: got %b want 0", valid_3);
        end
    endtask

    task automatic test_back_to_back();
        allow_4 = 1'b1;
        data_sram_addr_ok = 1'b1;
        valid_2 = 1'b1;
        stage_2_to_3 = mk_bus(1'b1, 5'd6, 1'b1, 32'h3000, 32'h0, OP_ADD, 1'b0, 1'b1, 32'h500);
        step();
        stage_2_to_3 = mk_bus(1'b1, 5'd7, 1'b1, 32'h3000, 32'h4, OP_ADD, 1'b0, 1'b1, 32'h504);
        #1;
        checks++;
        if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h3000 || allow_3 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: got req=%b addr=%h allow=%b want 1 00003000 1",
                     data_sram_req, data_sram_addr, allow_3);
        end
        step();
        valid_2 = 1'b0;
        #1;
        checks++;
        if (data_sram_req !== 1'b1 || data_sram_addr !== 32'h3004 || valid_3 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: got req=%b addr=%h valid=%b want 1 00003004 1",
                     data_sram_req, data_sram_addr, valid_3);
        end
        step();
        data_sram_addr_ok = 1'b0;
        checks++;
        if (valid_3 !== 1'b0 || data_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got valid=%b req=%b want 0 0", valid_3, data_sram_req);
        end
    endtask

    task automatic test_reset_mid();
        allow_4 = 1'b1;
        data_sram_addr_ok = 1'b0;
        valid_2 = 1'b1;
        stage_2_to_3 = mk_bus(1'b1, 5'd12, 1'b1, 32'h4000, 32'h0, OP_ADD, 1'b0, 1'b1, 32'h600);
        step();
        valid_2 = 1'b0;
        #1;
        checks++;
        if (data_sram_req !== 1'b1 || rf_waddr_3_fwd !== 5'd12) begin
            errors++;
            $display("FAIL rst_mid_pre: got req=%b waddr=%0d want 1 12", data_sram_req,
                     rf_waddr_3_fwd);
        end
        reset = 1'b1;
        step();
        checks++;
        if (valid_3 !== 1'b0 || data_sram_req !== 1'b0 || rf_waddr_3_fwd !== 5'd0) begin
            errors++;
            $display("FAIL rst_mid_post: got valid=%b req=%b waddr=%0d want 0 0 0", valid_3,
                     data_sram_req, rf_waddr_3_fwd);
        end
        reset = 1'b0;
        step();
        checks++;
        if (valid_3 !== 1'b0 || data_sram_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got valid=%b req=%b want 0 0", valid_3, data_sram_req);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu();
        test_store();
        test_load_stall();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_3_ex.md
Name: stage_3_EX

Overview:
- Execute stage of the 5-stage in-order pipeline; sits between stage_2_ID and the memory-access stage.
- Registers the 117-bit ID bus and the store data, computes the ALU result, and issues data-memory requests over the SRAM-like req/addr_ok bus.
- Stalls on memory address handshake and exports its write address for ID hazard detection.

Parameters:
- BUS_2_3_W, 117, width of ID->EX bus
- BUS_3_4_W, 71, width of EX->MEM bus

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_2  in  1  ID holds a valid instruction
- allow_3  out  1  EX can accept a new instruction this cycle
- valid_3  out  1  EX holds a valid instruction
- allow_4  in  1  MEM stage can accept
- stage_2_to_3  in  117  {rf_we, dest[4:0], res_from_mem, alu_src1[31:0], alu_src2[31:0], alu_op[11:0], mem_we, mem_en, pc[31:0]}
- memory_write_data  in  32  store data from ID
- stage_3_to_4  out  71  {rf_we, dest[4:0], res_from_mem, alu_result[31:0], pc[31:0]}
- rf_waddr_3_fwd  out  5  dest if valid_3 & rf_we, else 0
- data_sram_req  out  1  memory request
- data_sram_wr  out  1  1 = store
- data_sram_wstrb  out  4  byte strobe
- data_sram_addr  out  32  byte address = alu_result
- data_sram_wdata  out  32  store data
- data_sram_addr_ok  in  1  request accepted this cycle

Behaviour:
- Clock/reset: single clock clk; reset synchronous, active-high.
- Reset values: valid_3=0; FSM state=IDLE; captured bus and data registers=0. All outputs gated by valid_3, so they are 0 after reset.
- Pipeline handshake:
  - readygo_3 = ~mem_en | (state==ISSUED) | (state==WAIT_ADDR & data_sram_addr_ok).
  - allow_3 = ~valid_3 | (readygo_3 & allow_4).
  - On an edge with allow_3=1: valid_3<=valid_2, and the bus and store data are captured only if valid_2=1.
  - On an edge with allow_3=0: the stage holds.
- Latency: one cycle per instruction when no memory op is pending. A memory op waits until addr_ok.
- ALU (combinational on registered operands), alu_op one-hot:
  - bit0 add; bit1 sub; bit2 signed slt; bit3 sltu; bit4 and; bit5 nor; bit6 or; bit7 xor.
  - bit8 sll, bit9 srl, bit10 sra: shift amount = src2[4:0].
  - bit11 lui: result = src2.
  - Results are 32-bit with wrap-around and no overflow trap.
  - All-zero alu_op gives result 0.
- Memory FSM:
  - States: IDLE, WAIT_ADDR, ISSUED.
  - Whenever a newly captured instruction has valid_2 & mem_en, state<=WAIT_ADDR. Any other capture gives IDLE.
  - WAIT_ADDR & addr_ok & ~(allow_4) -> ISSUED.
  - When the instruction leaves the stage, the next state follows the rule for the newly captured instruction.
  - data_sram_req = valid_3 & mem_en & (state==WAIT_ADDR).
  - data_sram_wr=mem_we; wstrb=mem_we?4'hF:4'h0; wdata=captured store data.
  - Request fields are stable while req=1.
  - No second request is issued for the same instruction (ISSUED blocks req).
- Simultaneous events: addr_ok and allow_4 in the same cycle means the instruction advances directly. A new instruction is captured on that same edge.
- Reset mid-request: the next edge clears valid_3 and returns state to IDLE; req drops after that edge.
- Optional stage flush: not part of this block; branch squash happens in ID.

Optional Feature:
- Macro: EX_DATA_FWD_EN.
- Enabled: adds output rf_wdata_3_fwd[31:0] = alu_result and rf_fwd_ok_3 = valid_3 & rf_we & ~res_from_mem. ID can bypass instead of stalling on non-load EX hazards.
- Disabled: these ports are absent; ID stalls on every EX hazard.

Decomposition:
- Shared package: BUS_2_3_W, BUS_3_4_W, alu_op bit index constants (ALU_ADD..ALU_LUI), FSM state encoding.
- One sub-module: ex_alu (alu_op, src1, src2 -> result), purely combinational.

Test Plan:
- Reset, then add (src1=5, src2=7, valid_2=1, allow_4=1) -> next cycle valid_3=1, alu_result=12, rf_waddr_3_fwd=dest, allow_3=1.
- sra with src1=0x80000000, src2=4 -> 0xF8000000. sltu 1 vs 0xFFFFFFFF -> 1. slt with the same operands -> 0.
- Store (mem_en=1, mem_we=1, addr=0x1000+0x8, data=0xDEADBEEF), addr_ok held low 3 cycles -> req=1, wr=1, wstrb=F, addr=0x1008 stable. allow_3=0 until addr_ok; advance on the addr_ok cycle.
- Load with addr_ok=1 but allow_4=0 for 2 cycles -> state ISSUED, req drops after 1 cycle, valid_3 held. Advances when allow_4=1 with exactly one request issued.
- Back-to-back loads, both with addr_ok immediate -> two req pulses on consecutive cycles, no bubble.
- Reset asserted while in WAIT_ADDR -> after the edge valid_3=0, req=0, rf_waddr_3_fwd=0.
